// File: rtl/cyl_pkg.sv
// Shared widths, the stage-1 pipeline record and the Q16 tangent table
// used by the cartesian-to-cylindrical converter.
package cyl_pkg;

    localparam int COORD_W = 8;
    localparam int SUM_W   = 17;
    localparam int ROOT_W  = 9;
    localparam int TAN_W   = 22;
    localparam int PROD_W  = COORD_W + TAN_W;
    localparam int N_DEG   = 89;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t             x;
        coord_t             y;
        coord_t             z;
        logic [SUM_W-1:0]   s;
    } stage1_t;

    // ceil(tan(d deg) * 65536); rounding up makes the compare yield floor(angle)
    localparam logic [TAN_W-1:0] TAN_Q16 [1:N_DEG] = '{
        22'd1144,
        22'd2289,
        22'd3435,
        22'd4583,
        22'd5734,
        22'd6889,
        22'd8047,
        22'd9211,
        22'd10380,
        22'd11556,
        22'd12739,
        22'd13931,
        22'd15131,
        22'd16340,
        22'd17561,
        22'd18793,
        22'd20037,
        22'd21294,
        22'd22566,
        22'd23854,
        22'd25157,
        22'd26479,
        22'd27819,
        22'd29179,
        22'd30560,
        22'd31965,
        22'd33393,
        22'd34847,
        22'd36328,
        22'd37838,
        22'd39379,
        22'd40952,
        22'd42560,
        22'd44205,
        22'd45889,
        22'd47615,
        22'd49385,
        22'd51203,
        22'd53071,
        22'd54992,
        22'd56970,
        22'd59009,
        22'd61114,
        22'd63288,
        22'd65536,
        22'd67865,
        22'd70279,
        22'd72786,
        22'd75391,
        22'd78103,
        22'd80931,
        22'd83883,
        22'd86970,
        22'd90203,
        22'd93596,
        22'd97162,
        22'd100917,
        22'd104880,
        22'd109071,
        22'd113512,
        22'd118231,
        22'd123256,
        22'd128622,
        22'd134369,
        22'd140543,
        22'd147197,
        22'd154394,
        22'd162208,
        22'd170728,
        22'd180059,
        22'd190331,
        22'd201700,
        22'd214359,
        22'd228552,
        22'd244584,
        22'd262851,
        22'd283868,
        22'd308323,
        22'd337154,
        22'd371674,
        22'd413779,
        22'd466313,
        22'd533748,
        22'd623534,
        22'd749080,
        22'd937209,
        22'd1250502,
        22'd1876706,
        22'd3754555
    };

    function automatic coord_t sat_root(input logic [ROOT_W-1:0] q);
        return (q > ROOT_W'(255)) ? 8'hFF : q[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/cyl_isqrt17.sv
// Combinational restoring integer square root: q = floor(sqrt(s)),
// one result bit per unrolled iteration, most significant first.
module isqrt17
    import cyl_pkg::*;
(
    input  logic [SUM_W-1:0]  s,
    output logic [ROOT_W-1:0] q
);

    logic [SUM_W:0]        s_pad;
    logic [11:0]           rem;
    logic [11:0]           trial;
    logic [ROOT_W-1:0]     root;

    always_comb begin
        s_pad = {1'b0, s};
        rem   = '0;
        trial = '0;
        root  = '0;
        // remainder never exceeds 2*root (<= 720), so its top two bits are free to shift out
        for (int i = ROOT_W - 1; i >= 0; i--) begin
            rem   = {rem[9:0], s_pad[2*i+1 -: 2]};
            trial = {1'b0, root, 2'b01};
            if (rem >= trial) begin
                rem  = rem - trial;
                root = {root[ROOT_W-2:0], 1'b1};
            end else begin
                root = {root[ROOT_W-2:0], 1'b0};
            end
        end
        q = root;
    end

endmodule

// File: rtl/tt_um_project_cyl.sv
// Two-stage cartesian-to-cylindrical converter: stage 1 latches the point and x^2+y^2,
// stage 2 registers the saturated root, the floor angle in degrees and the delayed z.
module tt_um_project_cyl
    import cyl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] z,
    output logic [COORD_W-1:0] r,
    output logic [COORD_W-1:0] theta,
    output logic [COORD_W-1:0] z_out
);

    stage1_t            st1_d, st1_q;
    logic [ROOT_W-1:0]  root;
    logic [PROD_W-1:0]  y_scaled;
    logic [6:0]         tan_hits;
    coord_t             r_d, r_q;
    coord_t             theta_d, theta_q;
    coord_t             z_out_d, z_out_q;

    always_comb begin
        st1_d.x = x;
        st1_d.y = y;
        st1_d.z = z;
        st1_d.s = SUM_W'(x) * SUM_W'(x) + SUM_W'(y) * SUM_W'(y);
    end

    isqrt17 u_isqrt (
        .s (st1_q.s),
        .q (root)
    );

    // Count thresholds passed; the table is monotonic so the count is the floor angle.
    always_comb begin
        y_scaled = PROD_W'({st1_q.y, 16'h0000});
        tan_hits = '0;
        for (int d = 1; d <= N_DEG; d++) begin
            if (y_scaled >= PROD_W'(st1_q.x) * PROD_W'(TAN_Q16[d])) begin
                tan_hits = tan_hits + 7'd1;
            end
        end
        if (st1_q.x == '0) begin
            theta_d = (st1_q.y == '0) ? 8'd0 : 8'd90;
        end else begin
            theta_d = {1'b0, tan_hits};
        end
        r_d     = sat_root(root);
        z_out_d = st1_q.z;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st1_q   <= '0;
            r_q     <= '0;
            theta_q <= '0;
            z_out_q <= '0;
        end else begin
            st1_q   <= st1_d;
            r_q     <= r_d;
            theta_q <= theta_d;
            z_out_q <= z_out_d;
        end
    end

    assign r     = r_q;
    assign theta = theta_q;
    assign z_out = z_out_q;

endmodule

// File: tb/tb_tt_um_project_cyl.sv
// Bench for the cylindrical converter: directed points with hand-derived results,
// mid-stream reset, then random points checked against a real-arithmetic model.
module tb_tt_um_project_cyl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] x, y, z;
    logic [7:0] r, theta, z_out;

    always #5 clk = ~clk;

    tt_um_project_cyl dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .y     (y),
        .z     (z),
        .r     (r),
        .theta (theta),
        .z_out (z_out)
    );

    typedef struct {
        int r;
        int th;
        int z;
    } res_t;

    res_t in_flight = '{0, 0, 0};
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_step    = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s step %0d: got %0d, want %0d", tag, n_step, obs, exp);
    endtask

    function automatic res_t ref_point(input int xi, input int yi, input int zi);
        res_t res;
        int   s;
        int   q;
        real  ang;
        s = xi * xi + yi * yi;
        q = 0;
        while ((q + 1) * (q + 1) <= s) q++;
        res.r = (q > 255) ? 255 : q;
        if (xi == 0) res.th = (yi == 0) ? 0 : 90;
        else if (xi == yi) res.th = 45;
        else begin
            ang    = $atan2(real'(yi), real'(xi)) * 180.0 / 3.14159265358979323846;
            res.th = $rtoi(ang);
        end
        res.z = zi;
        return res;
    endfunction

    // One clock: drive at negedge, let the edge happen, check at the next negedge.
    task automatic step(input bit rst_i, input int xi, input int yi, input int zi,
                        input bit pinned, input int er, input int et);
        res_t nxt;
        res_t due;
        rst = rst_i;
        x   = xi[7:0];
        y   = yi[7:0];
        z   = zi[7:0];
        nxt = pinned ? '{er, et, zi} : ref_point(xi, yi, zi);
        @(posedge clk);
        if (rst_i) begin
            due       = '{0, 0, 0};
            in_flight = '{0, 0, 0};
        end else begin
            due       = in_flight;
            in_flight = nxt;
        end
        @(negedge clk);
        n_step++;
        check_val("r", int'(r), due.r);
        check_val("theta", int'(theta), due.th);
        check_val("z_out", int'(z_out), due.z);
    endtask

    int dx [8] = '{10, 0, 7, 15, 1, 5, 0, 255};
    int dy [8] = '{0, 10, 7, 15, 1, 12, 0, 255};
    int dz [8] = '{5, 5, 8, 1, 1, 3, 9, 255};
    int er [8] = '{10, 10, 9, 21, 1, 13, 0, 255};
    int et [8] = '{0, 90, 45, 45, 45, 67, 0, 45};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int xi, yi, kind;
        rst = 1'b1;
        x = '0;
        y = '0;
        z = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b1, 17, 33, 44, 1'b0, 0, 0);

        for (int i = 0; i < 8; i++) step(1'b0, dx[i], dy[i], dz[i], 1'b1, er[i], et[i]);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 1'b0, 0, 0);

        for (int i = 0; i < 8; i++) step(i == 4, dx[i], dy[i], dz[i], 1'b1, er[i], et[i]);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 1'b0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            xi   = int'($urandom_range(0, 255));
            yi   = int'($urandom_range(0, 255));
            kind = int'($urandom_range(0, 15));
            if (kind == 0) yi = xi;
            else if (kind == 1) xi = 0;
            else if (kind == 2) yi = 0;
            else if (kind == 3) begin
                xi = int'($urandom_range(200, 255));
                yi = int'($urandom_range(200, 255));
            end
            step($urandom_range(0, 49) == 0, xi, yi, int'($urandom_range(0, 255)),
                 1'b0, 0, 0);
        end
        for (int i = 0; i < 2; i++) step(1'b0, 0, 0, 0, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
